ball_control: RTL and testbench

- Pong ball engine for the 1024x768 XGA game screen, in the 65 MHz pixel clock domain.
- Moves the ball once per video frame, bounces it off the top/bottom walls and the paddles, and detects misses.
- Keeps each player's 4-bit score and hands the ball position (top-left corner) to the draw logic.

---
 rtl/ball_control.sv | 162 ++++++++++++++++
 tb/tb_ball_control.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_control.sv
// rtl/ball_control.sv - Pong ball engine: frame-rate ball motion, wall/paddle bounces, miss scoring
module ball_control #(
    parameter int H_RES      = 1024,
    parameter int V_RES      = 768,
    parameter int BALL_SIZE  = 16,
    parameter int PADDLE_W   = 16,
    parameter int PADDLE_H   = 96,
    parameter int PADDLE_L_X = 32,
    parameter int PADDLE_R_X = 976,
    parameter int STEP       = 4,
    parameter int MAX_POINTS = 15
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        end_of_frame,
    input  logic        serve,
    input  logic [9:0]  pos_of_player_1,
    input  logic [9:0]  pos_of_player_2,
    input  logic        screen_idle,
    input  logic        screen_multi,
    output logic [3:0]  points_player_1,
    output logic [3:0]  points_player_2,
    output logic [10:0] x_pos_of_ball,
    output logic [10:0] y_pos_of_ball
);

    typedef enum logic [1:0] {
        WAIT_SERVE = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    localparam logic [10:0]        X_CENTRE = 11'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [10:0]        Y_CENTRE = 11'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] Y_MAX    = 12'(V_RES - BALL_SIZE);
    localparam logic signed [11:0] X_MISS_R = 12'(H_RES - BALL_SIZE);
    localparam logic signed [11:0] X_HIT_L  = 12'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [11:0] X_HIT_R  = 12'(PADDLE_R_X - BALL_SIZE);
    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic [3:0]         MAX_PTS  = 4'(MAX_POINTS);

    state_t      state, state_n;
    logic        dx_pos, dy_pos, dx_pos_n, dy_pos_n;
    logic [10:0] x_n, y_n;
    logic [3:0]  p1_n, p2_n;

    logic signed [11:0] x_s, y_s, nx, ny;
    logic [11:0]        y_u, pad1, pad2;
    logic               overlap_1, overlap_2, hit_l, hit_r;
    logic [3:0]         p1_inc, p2_inc;

    // 12-bit signed so a step past 0 shows up as negative instead of wrapping
    assign x_s = $signed({1'b0, x_pos_of_ball});
    assign y_s = $signed({1'b0, y_pos_of_ball});
    assign nx  = dx_pos ? x_s + STEP_S : x_s - STEP_S;
    assign ny  = dy_pos ? y_s + STEP_S : y_s - STEP_S;

    assign y_u  = {1'b0, y_pos_of_ball};
    assign pad1 = {2'b00, pos_of_player_1};
    assign pad2 = {2'b00, pos_of_player_2};
    assign overlap_1 = (y_u + 12'(BALL_SIZE) > pad1) && (y_u < pad1 + 12'(PADDLE_H));
    assign overlap_2 = (y_u + 12'(BALL_SIZE) > pad2) && (y_u < pad2 + 12'(PADDLE_H));

    assign hit_l = !dx_pos && (nx <= X_HIT_L) && (x_s >= X_HIT_L) && overlap_1;
    // single-player: the right side is a solid full-height wall
    assign hit_r = dx_pos && (nx >= X_HIT_R) &&
                   (!screen_multi || ((x_s <= X_HIT_R) && overlap_2));

    assign p1_inc = (points_player_1 == MAX_PTS) ? MAX_PTS : points_player_1 + 4'd1;
    assign p2_inc = (points_player_2 == MAX_PTS) ? MAX_PTS : points_player_2 + 4'd1;

    always_ff @(posedge clk65MHz or negedge rst) begin
        if (!rst) begin
            state           <= WAIT_SERVE;
            x_pos_of_ball   <= X_CENTRE;
            y_pos_of_ball   <= Y_CENTRE;
            dx_pos          <= 1'b1;
            dy_pos          <= 1'b1;
            points_player_1 <= 4'd0;
            points_player_2 <= 4'd0;
        end else begin
            state           <= state_n;
            x_pos_of_ball   <= x_n;
            y_pos_of_ball   <= y_n;
            dx_pos          <= dx_pos_n;
            dy_pos          <= dy_pos_n;
            points_player_1 <= p1_n;
            points_player_2 <= p2_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_pos_of_ball;
        y_n      = y_pos_of_ball;
        dx_pos_n = dx_pos;
        dy_pos_n = dy_pos;
        p1_n     = points_player_1;
        p2_n     = points_player_2;
        if (end_of_frame) begin
            if (screen_idle) begin
                state_n  = WAIT_SERVE;
                x_n      = X_CENTRE;
                y_n      = Y_CENTRE;
                dx_pos_n = 1'b1;
                dy_pos_n = 1'b1;
                p1_n     = 4'd0;
                p2_n     = 4'd0;
            end else begin
                case (state)
                    WAIT_SERVE: begin
                        x_n = X_CENTRE;
                        y_n = Y_CENTRE;
                        if (serve) state_n = PLAY;
                    end
                    PLAY: begin
                        if (ny <= 12'sd0) begin
                            y_n      = 11'd0;
                            dy_pos_n = 1'b1;
                        end else if (ny >= Y_MAX) begin
                            y_n      = Y_MAX[10:0];
                            dy_pos_n = 1'b0;
                        end else begin
                            y_n = ny[10:0];
                        end

                        if (hit_l) begin
                            x_n      = X_HIT_L[10:0];
                            dx_pos_n = 1'b1;
                        end else if (hit_r) begin
                            x_n      = X_HIT_R[10:0];
                            dx_pos_n = 1'b0;
                        end else if (nx <= 12'sd0) begin
                            // miss overrides the wall result; serve goes toward the loser
                            p2_n     = p2_inc;
                            x_n      = X_CENTRE;
                            y_n      = Y_CENTRE;
                            dx_pos_n = 1'b0;
                            dy_pos_n = dy_pos;
                            state_n  = (p2_inc == MAX_PTS) ? GAME_OVER : WAIT_SERVE;
                        end else if (nx >= X_MISS_R) begin
                            p1_n     = p1_inc;
                            x_n      = X_CENTRE;
                            y_n      = Y_CENTRE;
                            dx_pos_n = 1'b1;
                            dy_pos_n = dy_pos;
                            state_n  = (p1_inc == MAX_PTS) ? GAME_OVER : WAIT_SERVE;
                        end else begin
                            x_n = nx[10:0];
                        end
                    end
                    GAME_OVER: begin
                        x_n = X_CENTRE;
                        y_n = Y_CENTRE;
                    end
                    default: state_n = WAIT_SERVE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_control.sv
// tb/tb_ball_control.sv - self-checking bench for ball_control: vector table, scenarios, random vs model
module tb_ball_control;

    logic        clk65MHz;
    logic        rst;
    logic        end_of_frame;
    logic        serve;
    logic [9:0]  pos_of_player_1;
    logic [9:0]  pos_of_player_2;
    logic        screen_idle;
    logic        screen_multi;
    logic [3:0]  points_player_1;
    logic [3:0]  points_player_2;
    logic [10:0] x_pos_of_ball;
    logic [10:0] y_pos_of_ball;

    ball_control dut (
        .clk65MHz        (clk65MHz),
        .rst             (rst),
        .end_of_frame    (end_of_frame),
        .serve           (serve),
        .pos_of_player_1 (pos_of_player_1),
        .pos_of_player_2 (pos_of_player_2),
        .screen_idle     (screen_idle),
        .screen_multi    (screen_multi),
        .points_player_1 (points_player_1),
        .points_player_2 (points_player_2),
        .x_pos_of_ball   (x_pos_of_ball),
        .y_pos_of_ball   (y_pos_of_ball)
    );

    initial clk65MHz = 1'b0;
    always #5 clk65MHz = ~clk65MHz;

    int checks   = 0;
    int failures = 0;

    localparam int CX = 504;
    localparam int CY = 376;

    // reference model: plain integers, direction as +1/-1, state 0=wait 1=play 2=over
    int mx, my, mdx, mdy, mp1, mp2, mst;

    task automatic model_reset();
        mx = CX; my = CY; mdx = 1; mdy = 1; mp1 = 0; mp2 = 0; mst = 0;
    endtask

    task automatic model_step();
        int nx, ny, tx, ty, tdx, tdy, a1, a2;
        bit ovl, ovr;
        if (!rst) begin model_reset(); return; end
        if (!end_of_frame) return;
        if (screen_idle) begin model_reset(); return; end
        if (mst != 1) begin
            mx = CX; my = CY;
            if (mst == 0 && serve) mst = 1;
            return;
        end
        a1 = int'(pos_of_player_1);
        a2 = int'(pos_of_player_2);
        nx = mx + 4 * mdx;
        ny = my + 4 * mdy;
        tdx = mdx; tdy = mdy;
        if (ny <= 0) begin ty = 0; tdy = 1; end
        else if (ny >= 752) begin ty = 752; tdy = -1; end
        else ty = ny;
        ovl = (my + 16 > a1) && (my < a1 + 96);
        ovr = !screen_multi || ((my + 16 > a2) && (my < a2 + 96) && mx <= 960);
        if (mdx < 0 && nx <= 48 && mx >= 48 && ovl) begin
            tx = 48; tdx = 1;
        end else if (mdx > 0 && nx >= 960 && ovr) begin
            tx = 960; tdx = -1;
        end else if (nx <= 0) begin
            if (mp2 < 15) mp2 = mp2 + 1;
            mx = CX; my = CY; mdx = -1;
            mst = (mp2 == 15) ? 2 : 0;
            return;
        end else if (nx >= 1008) begin
            if (mp1 < 15) mp1 = mp1 + 1;
            mx = CX; my = CY; mdx = 1;
            mst = (mp1 == 15) ? 2 : 0;
            return;
        end else begin
            tx = nx;
        end
        mx = tx; my = ty; mdx = tdx; mdy = tdy;
    endtask

    task automatic tick();
        @(posedge clk65MHz);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        checks++;
        if (int'(x_pos_of_ball) != mx || int'(y_pos_of_ball) != my ||
            int'(points_player_1) != mp1 || int'(points_player_2) != mp2) begin
            failures++;
            $display("FAIL %s @%0t: got x=%0d y=%0d p1=%0d p2=%0d expected x=%0d y=%0d p1=%0d p2=%0d",
                     name, $time, x_pos_of_ball, y_pos_of_ball, points_player_1, points_player_2,
                     mx, my, mp1, mp2);
        end
    endtask

    function automatic logic [9:0] track(input int y);
        return (y >= 40) ? 10'(y - 40) : 10'd0;
    endfunction

    typedef struct {
        bit    eof, srv, idl;
        int    ex, ey, e1, e2;
        string name;
    } vec_t;

    function automatic vec_t mk(input bit eof, input bit srv, input bit idl,
                                input int ex, input int ey, input string name);
        vec_t v;
        v.eof = eof; v.srv = srv; v.idl = idl;
        v.ex = ex; v.ey = ey; v.e1 = 0; v.e2 = 0; v.name = name;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        bit done;
        int saw_752, saw_960, saw_48, y_down;

        rst = 1'b0; end_of_frame = 1'b0; serve = 1'b0; screen_idle = 1'b0;
        screen_multi = 1'b1; pos_of_player_1 = 10'd300; pos_of_player_2 = 10'd300;
        model_reset();
        tick(); tick();
        chk("reset_x", int'(x_pos_of_ball), 504);
        chk("reset_y", int'(y_pos_of_ball), 376);
        chk("reset_p1", int'(points_player_1), 0);
        chk("reset_p2", int'(points_player_2), 0);
        rst = 1'b1;

        // directed vector table: serve latency, frame gating, idle behaviour
        for (int i = 0; i < 4; i++) vq.push_back(mk(1, 0, 0, 504, 376, "hold"));
        vq.push_back(mk(0, 1, 0, 504, 376, "serve_no_eof"));
        vq.push_back(mk(1, 0, 0, 504, 376, "still_wait"));
        vq.push_back(mk(1, 1, 0, 504, 376, "serve_frame"));
        vq.push_back(mk(1, 0, 0, 508, 380, "move1"));
        vq.push_back(mk(0, 0, 0, 508, 380, "no_eof_hold"));
        vq.push_back(mk(1, 0, 0, 512, 384, "move2"));
        vq.push_back(mk(1, 0, 1, 504, 376, "idle_centre"));
        vq.push_back(mk(1, 1, 1, 504, 376, "idle_ignores_serve"));
        vq.push_back(mk(1, 0, 0, 504, 376, "wait_after_idle"));
        for (int i = 0; i < vq.size(); i++) begin
            end_of_frame = vq[i].eof; serve = vq[i].srv; screen_idle = vq[i].idl;
            tick();
            chk({"vec_", vq[i].name, "_x"}, int'(x_pos_of_ball), vq[i].ex);
            chk({"vec_", vq[i].name, "_y"}, int'(y_pos_of_ball), vq[i].ey);
            chk({"vec_", vq[i].name, "_pts"},
                int'({points_player_1, points_player_2}), (vq[i].e1 << 4) | vq[i].e2);
        end
        screen_idle = 1'b0; serve = 1'b0; end_of_frame = 1'b1;

        // bottom bounce then right miss
        pos_of_player_2 = 10'd0; pos_of_player_1 = 10'd0;
        serve = 1'b1; tick(); serve = 1'b0;
        done = 0; saw_752 = 0; y_down = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            int py;
            py = int'(y_pos_of_ball);
            tick();
            chk_model("t3_track");
            if (y_pos_of_ball == 11'd752) saw_752 = 1;
            if (saw_752 && int'(y_pos_of_ball) < py && y_pos_of_ball != 11'd376) y_down = 1;
            if (points_player_1 == 4'd1) done = 1;
        end
        chk("t3_bottom_bounce", saw_752, 1);
        chk("t3_y_decreasing", y_down, 1);
        chk("t3_p1_scored", int'(points_player_1), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_no_motion_x", int'(x_pos_of_ball), 504);
        chk("t3_no_motion_y", int'(y_pos_of_ball), 376);

        // paddles follow the ball: rally without scoring
        serve = 1'b1; tick(); serve = 1'b0;
        saw_960 = 0; saw_48 = 0;
        for (int i = 0; i < 700; i++) begin
            pos_of_player_1 = track(my); pos_of_player_2 = track(my);
            tick();
            chk_model("t4_rally");
            if (x_pos_of_ball == 11'd960) saw_960++;
            if (x_pos_of_ball == 11'd48) saw_48++;
        end
        chk("t4_right_hit", int'(saw_960 > 0), 1);
        chk("t4_left_hit", int'(saw_48 > 0), 1);
        chk("t4_p1_unchanged", int'(points_player_1), 1);
        chk("t4_p2_zero", int'(points_player_2), 0);

        // repeated right misses to game over
        pos_of_player_2 = 10'd1023; serve = 1'b1;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            pos_of_player_1 = track(my);
            tick();
            chk_model("t5_run");
            if (points_player_1 == 4'd15) done = 1;
        end
        chk("t5_p1_max", int'(points_player_1), 15);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_over_x", int'(x_pos_of_ball), 504);
        chk("t5_over_y", int'(y_pos_of_ball), 376);
        chk("t5_p1_saturated", int'(points_player_1), 15);
        serve = 1'b0; screen_idle = 1'b1; tick(); screen_idle = 1'b0;
        chk("t5_idle_p1", int'(points_player_1), 0);
        chk("t5_idle_x", int'(x_pos_of_ball), 504);

        // single-player: solid right wall, left miss scores for player 2
        screen_multi = 1'b0; pos_of_player_2 = 10'd0; pos_of_player_1 = 10'd1023;
        serve = 1'b1; tick(); serve = 1'b0;
        done = 0; saw_960 = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            chk_model("t6_run");
            if (x_pos_of_ball == 11'd960) saw_960++;
            if (points_player_2 == 4'd1) done = 1;
        end
        chk("t6_wall_reflect", int'(saw_960 > 0), 1);
        chk("t6_p1_zero", int'(points_player_1), 0);
        chk("t6_p2_one", int'(points_player_2), 1);

        // randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            end_of_frame = ($urandom_range(0, 3) != 0);
            serve        = ($urandom_range(0, 7) == 0);
            screen_idle  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 199) == 0) screen_multi = ~screen_multi;
            pos_of_player_1 = ($urandom_range(0, 1) == 0) ? track(my) : 10'($urandom_range(0, 1023));
            pos_of_player_2 = ($urandom_range(0, 1) == 0) ? track(my) : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b0;
                #1;
                chk("rand_async_reset_x", int'(x_pos_of_ball), 504);
                chk("rand_async_reset_pts",
                    int'({points_player_1, points_player_2}), 0);
                model_reset();
                tick();
                rst = 1'b1;
            end
            tick();
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
